// File: rtl/wrr_lock_arbiter.sv
// 4-requester weighted round-robin arbiter with grant locking for up to weight[i] beats.
// Optional stall timeout release when WRR_TIMEOUT_EN is defined.
module wrr_lock_arbiter #(
  parameter int unsigned WEIGHT_W = 4,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic                  rdy,
  input  logic                  cfg_we,
  input  logic [4*WEIGHT_W-1:0] cfg_wdata,
  output logic [3:0]            gnt,
  output logic                  gnt_vld,
  output logic [1:0]            gnt_id,
  output logic [WEIGHT_W-1:0]   credit,
  output logic                  timeout
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e              state_q;
  logic [3:0]          gnt_q;
  logic                gnt_vld_q;
  logic [1:0]          gnt_id_q;
  logic [1:0]          ptr_q;
  logic [WEIGHT_W-1:0] credit_q;
  logic [WEIGHT_W-1:0] weight_q [4];

  logic                beat;
  logic                tmo_fire;
  logic                rel;
  logic                arb;
  logic                pick_vld;
  logic [1:0]          pick_id;
  logic [1:0]          idx;
  logic [WEIGHT_W-1:0] pick_w;
  logic [WEIGHT_W-1:0] pick_eff;

  // Search order ptr+1, ptr+2, ptr+3, ptr: the holder re-wins only when it is the sole requester.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = ptr_q;
    idx      = ptr_q;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx;
      end
    end
    pick_w   = weight_q[pick_id];
    pick_eff = (pick_w == '0) ? WEIGHT_W'(1) : pick_w;
  end

  assign beat = gnt_vld_q & req[gnt_id_q] & rdy;
  assign rel  = (state_q == GRANT) &
                (~req[gnt_id_q] | (beat & (credit_q == WEIGHT_W'(1))) | tmo_fire);
  assign arb  = (state_q == IDLE) | rel;

`ifdef WRR_TIMEOUT_EN
  localparam int unsigned ST_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [ST_W-1:0] stall_q;
  logic            stalled;
  logic            timeout_q;

  assign stalled  = gnt_vld_q & req[gnt_id_q] & ~rdy;
  assign tmo_fire = stalled & (stall_q == ST_W'(TIMEOUT - 1));
  assign timeout  = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= tmo_fire;
      if (arb || !stalled) stall_q <= '0;
      else                 stall_q <= stall_q + ST_W'(1);
    end
  end
`else
  assign tmo_fire = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      gnt_id_q  <= '0;
      credit_q  <= '0;
      ptr_q     <= 2'd3;
      for (int unsigned i = 0; i < 4; i++) weight_q[i] <= WEIGHT_W'(1);
    end else begin
      if (cfg_we) begin
        for (int unsigned i = 0; i < 4; i++) weight_q[i] <= cfg_wdata[i*WEIGHT_W +: WEIGHT_W];
      end
      if (arb) begin
        if (pick_vld) begin
          state_q   <= GRANT;
          gnt_q     <= 4'b0001 << pick_id;
          gnt_vld_q <= 1'b1;
          gnt_id_q  <= pick_id;
          credit_q  <= pick_eff;
          ptr_q     <= pick_id;
        end else begin
          state_q   <= IDLE;
          gnt_q     <= '0;
          gnt_vld_q <= 1'b0;
          gnt_id_q  <= '0;
          credit_q  <= '0;
        end
      end else if (beat) begin
        credit_q <= credit_q - WEIGHT_W'(1);
      end
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = gnt_vld_q;
  assign gnt_id  = gnt_id_q;
  assign credit  = credit_q;

endmodule

// File: tb/tb_wrr_lock_arbiter.sv
// Directed scoreboard bench for wrr_lock_arbiter (default build, timeout feature off).
module tb_wrr_lock_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic        rdy = 1'b0;
  logic        cfg_we = 1'b0;
  logic [15:0] cfg_wdata = '0;
  logic [3:0]  gnt;
  logic        gnt_vld;
  logic [1:0]  gnt_id;
  logic [3:0]  credit;
  logic        timeout;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned step_no = 0;

  typedef struct {
    int unsigned tag;
    logic [3:0]  gnt;
    logic [3:0]  credit;
  } exp_t;

  exp_t sb [$];

  wrr_lock_arbiter #(.WEIGHT_W(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .rdy(rdy), .cfg_we(cfg_we), .cfg_wdata(cfg_wdata),
    .gnt(gnt), .gnt_vld(gnt_vld), .gnt_id(gnt_id), .credit(credit), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] enc(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic check_one(input string name, input int unsigned tag,
                           input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s step %0d: observed %b expected %b", name, tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic rd,
                      input logic we, input logic [15:0] wd,
                      input logic [3:0] eg, input logic [3:0] ec);
    exp_t e;
    @(negedge clk);
    rst = r; req = rq; rdy = rd; cfg_we = we; cfg_wdata = wd;
    step_no++;
    sb.push_back('{tag: step_no, gnt: eg, credit: ec});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard step %0d: observed empty expected entry", step_no);
    end else begin
      e = sb.pop_front();
      check_one("gnt",     e.tag, gnt,             e.gnt);
      check_one("gnt_vld", e.tag, {3'b0, gnt_vld}, {3'b0, |e.gnt});
      check_one("gnt_id",  e.tag, {2'b0, gnt_id},  {2'b0, enc(e.gnt)});
      check_one("credit",  e.tag, credit,          e.credit);
      check_one("timeout", e.tag, {3'b0, timeout}, 4'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    step(1, 4'h0, 1, 0, 16'h0, 4'b0000, 0);
    step(1, 4'hF, 1, 0, 16'h0, 4'b0000, 0);

    // all requesting, unit weights: plain rotation, no gaps
    step(0, 4'hF, 1, 0, 16'h0, 4'b0001, 1);
    step(0, 4'hF, 1, 0, 16'h0, 4'b0010, 1);
    step(0, 4'hF, 1, 0, 16'h0, 4'b0100, 1);
    step(0, 4'hF, 1, 0, 16'h0, 4'b1000, 1);
    step(0, 4'hF, 1, 0, 16'h0, 4'b0001, 1);
    step(0, 4'hF, 1, 0, 16'h0, 4'b0010, 1);
    step(0, 4'hF, 1, 0, 16'h0, 4'b0100, 1);
    step(0, 4'hF, 1, 0, 16'h0, 4'b1000, 1);
    step(0, 4'h0, 1, 0, 16'h0, 4'b0000, 0);

    // weights {3,2,1,0}, weight 0 acts as 1
    step(0, 4'h0, 1, 1, 16'h3210, 4'b0000, 0);
    step(0, 4'hF, 1, 0, 16'h0, 4'b0001, 1);
    step(0, 4'hF, 1, 0, 16'h0, 4'b0010, 1);
    step(0, 4'hF, 1, 0, 16'h0, 4'b0100, 2);
    step(0, 4'hF, 1, 0, 16'h0, 4'b0100, 1);
    step(0, 4'hF, 1, 0, 16'h0, 4'b1000, 3);
    step(0, 4'hF, 1, 0, 16'h0, 4'b1000, 2);
    step(0, 4'hF, 1, 0, 16'h0, 4'b1000, 1);
    step(0, 4'hF, 1, 0, 16'h0, 4'b0001, 1);
    step(0, 4'h0, 1, 0, 16'h0, 4'b0000, 0);

    // weights w3=1 w2=5 w1=2 w0=3; sole requester refills back-to-back
    step(0, 4'h0, 1, 1, 16'h1523, 4'b0000, 0);
    step(0, 4'b0010, 1, 0, 16'h0, 4'b0010, 2);
    step(0, 4'b0010, 1, 0, 16'h0, 4'b0010, 1);
    step(0, 4'b0010, 1, 0, 16'h0, 4'b0010, 2);
    step(0, 4'b0010, 1, 0, 16'h0, 4'b0010, 1);
    step(0, 4'b0010, 1, 0, 16'h0, 4'b0010, 2);
    step(0, 4'h0, 1, 0, 16'h0, 4'b0000, 0);

    // holder drops req with credit 3 left
    step(0, 4'b0001, 1, 0, 16'h0, 4'b0001, 3);
    step(0, 4'b0101, 0, 0, 16'h0, 4'b0001, 3);
    step(0, 4'b0100, 1, 0, 16'h0, 4'b0100, 5);

    // rdy low for 10 cycles: grant and credit frozen
    for (int i = 0; i < 10; i++) step(0, 4'b0100, 0, 0, 16'h0, 4'b0100, 5);
    step(0, 4'b0100, 1, 0, 16'h0, 4'b0100, 4);
    step(0, 4'h0, 1, 0, 16'h0, 4'b0000, 0);

    // cfg write coincident with load uses old weight; mid-grant write keeps credit
    step(0, 4'b1000, 1, 1, 16'h2523, 4'b1000, 1);
    step(0, 4'b1000, 1, 0, 16'h0, 4'b1000, 2);
    step(0, 4'b1000, 0, 1, 16'h7523, 4'b1000, 2);
    step(0, 4'b1000, 1, 0, 16'h0, 4'b1000, 1);
    step(0, 4'b1000, 1, 0, 16'h0, 4'b1000, 7);
    for (int c = 6; c >= 2; c--) step(0, 4'b1000, 1, 0, 16'h0, 4'b1000, 4'(c));

    // reset mid-grant restores weights and pointer
    step(1, 4'b1000, 1, 0, 16'h0, 4'b0000, 0);
    step(0, 4'b1000, 1, 0, 16'h0, 4'b1000, 1);
    step(0, 4'hF, 1, 0, 16'h0, 4'b0001, 1);
    step(0, 4'hF, 1, 0, 16'h0, 4'b0010, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
